// File: rtl/floo_axis_bridge_pkg.sv
// Shared definitions for the NoC-over-AXI-Stream bridge (RX and TX halves).
package floo_axis_bridge_pkg;

    typedef enum logic {
        HdrReq = 1'b0,
        HdrRsp = 1'b1
    } hdr_e;

    // Stream data width: payload plus one header bit, rounded up to whole bytes.
    function automatic int unsigned tdata_width(input int unsigned data_width);
        return ((data_width + 1 + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/floo_axis_rx_fifo.sv
// Per-channel flit buffer for the bridge RX half. Occupancy-counter based
// full/empty, async active-high reset, optional combinational bypass when empty.
module floo_axis_rx_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bypass_en_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [Width-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [Width-1:0] pop_data_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             empty, full, bypass, do_write, do_read;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CntW'(Depth));
    // A bypassed beat goes straight to the consumer and never occupies an entry.
    assign bypass   = bypass_en_i && empty && pop_ready_i && push_valid_i;
    assign do_write = push_valid_i && !full && !bypass;
    assign do_read  = !empty && pop_ready_i;

    assign push_ready_o = !full;
    assign pop_valid_o  = !empty || bypass;
    assign pop_data_o   = bypass ? push_data_i : mem_q[rptr_q];

    // Next pointers (wrap at Depth-1) and occupancy.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_write) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (do_read) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        if (do_write && !do_read) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_write && do_read) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage; cleared on reset so the data output reads zero afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/floo_axis_noc_bridge_rx.sv
// RX half of the NoC-over-AXI-Stream bridge: steers stream beats by header bit
// into independent request/response buffers and counts accepted beats.
// Optional feature macro: FLOO_AXIS_BRIDGE_RX_BYPASS_EN (0-cycle pass-through
// when the selected buffer is empty and its consumer is ready).
module floo_axis_noc_bridge_rx
    import floo_axis_bridge_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned ReqWidth   = 64,
    parameter int unsigned RspWidth   = 48,
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned TdataWidth = tdata_width(DataWidth)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  axis_tvalid_i,
    output logic                  axis_tready_o,
    input  logic [TdataWidth-1:0] axis_tdata_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ReqWidth-1:0]   req_data_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [RspWidth-1:0]   rsp_data_o,
    output logic [31:0]           req_cnt_o,
    output logic [31:0]           rsp_cnt_o
);

`ifdef FLOO_AXIS_BRIDGE_RX_BYPASS_EN
    localparam logic BypassEn = 1'b1;
`else
    localparam logic BypassEn = 1'b0;
`endif

    hdr_e        hdr;
    logic        req_push_valid, rsp_push_valid;
    logic        req_push_ready, rsp_push_ready;
    logic        accept;
    logic [31:0] req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
    logic        unused_tdata;

    // Pad bits and payload bits above a channel's width are deliberately dropped.
    assign unused_tdata = ^axis_tdata_i;

    assign hdr            = hdr_e'(axis_tdata_i[DataWidth]);
    assign req_push_valid = axis_tvalid_i && (hdr == HdrReq);
    assign rsp_push_valid = axis_tvalid_i && (hdr == HdrRsp);
    // tready comes only from registered occupancy, never from the consumer readies.
    assign axis_tready_o  = (hdr == HdrRsp) ? rsp_push_ready : req_push_ready;
    assign accept         = axis_tvalid_i && axis_tready_o;

    floo_axis_rx_fifo #(
        .Width (ReqWidth),
        .Depth (FifoDepth)
    ) i_req_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bypass_en_i  (BypassEn),
        .push_valid_i (req_push_valid),
        .push_ready_o (req_push_ready),
        .push_data_i  (axis_tdata_i[ReqWidth-1:0]),
        .pop_valid_o  (req_valid_o),
        .pop_ready_i  (req_ready_i),
        .pop_data_o   (req_data_o)
    );

    floo_axis_rx_fifo #(
        .Width (RspWidth),
        .Depth (FifoDepth)
    ) i_rsp_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bypass_en_i  (BypassEn),
        .push_valid_i (rsp_push_valid),
        .push_ready_o (rsp_push_ready),
        .push_data_i  (axis_tdata_i[RspWidth-1:0]),
        .pop_valid_o  (rsp_valid_o),
        .pop_ready_i  (rsp_ready_i),
        .pop_data_o   (rsp_data_o)
    );

    // Per-channel accepted-beat counters, wrapping naturally at 2^32.
    always_comb begin
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        if (accept && (hdr == HdrReq)) req_cnt_d = req_cnt_q + 32'd1;
        if (accept && (hdr == HdrRsp)) rsp_cnt_d = rsp_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    assign req_cnt_o = req_cnt_q;
    assign rsp_cnt_o = rsp_cnt_q;

`ifndef SYNTHESIS
    // A stalled beat must be held with unchanged header and payload.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (axis_tvalid_i && !axis_tready_o) |=>
            (axis_tvalid_i && $stable(axis_tdata_i[DataWidth:0])));
`endif

endmodule

// File: tb/tb_floo_axis_noc_bridge_rx.sv
// Bench for floo_axis_noc_bridge_rx: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_floo_axis_noc_bridge_rx;

    localparam int unsigned DW    = 64;
    localparam int unsigned QW    = 64;
    localparam int unsigned SW    = 48;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = ((DW + 1 + 7) / 8) * 8;
`ifdef FLOO_AXIS_BRIDGE_RX_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tvalid;
    logic          tready;
    logic [TW-1:0] tdata;
    logic          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [QW-1:0] req_data;
    logic [SW-1:0] rsp_data;
    logic [31:0]   req_cnt, rsp_cnt;

    int errors = 0;
    int checks = 0;

    floo_axis_noc_bridge_rx #(
        .DataWidth (DW),
        .ReqWidth  (QW),
        .RspWidth  (SW),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .axis_tvalid_i (tvalid),
        .axis_tready_o (tready),
        .axis_tdata_i  (tdata),
        .req_valid_o   (req_valid),
        .req_ready_i   (req_ready),
        .req_data_o    (req_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .req_cnt_o     (req_cnt),
        .rsp_cnt_o     (rsp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues of delivered-in-order flits and beat counts.
    logic [QW-1:0] mq_req[$];
    logic [SW-1:0] mq_rsp[$];
    logic [31:0]   m_req_cnt = '0;
    logic [31:0]   m_rsp_cnt = '0;

    // Compare process: inputs are stable at negedge; check, then advance model.
    always @(negedge clk) begin
        bit hdr, e_tready, byp_q, byp_s, e_qv, e_sv;
        if (rst) begin
            mq_req.delete();
            mq_rsp.delete();
            m_req_cnt = '0;
            m_rsp_cnt = '0;
            chk("rst_tready", tready, 1);
            chk("rst_req_valid", req_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_data", req_data, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_req_cnt", req_cnt, 0);
            chk("rst_rsp_cnt", rsp_cnt, 0);
        end else begin
            hdr      = tdata[DW];
            e_tready = hdr ? (mq_rsp.size() < DEPTH) : (mq_req.size() < DEPTH);
            byp_q    = Byp && mq_req.size() == 0 && req_ready && tvalid && !hdr;
            byp_s    = Byp && mq_rsp.size() == 0 && rsp_ready && tvalid && hdr;
            e_qv     = (mq_req.size() > 0) || byp_q;
            e_sv     = (mq_rsp.size() > 0) || byp_s;
            chk("tready", tready, e_tready);
            chk("req_valid", req_valid, e_qv);
            chk("rsp_valid", rsp_valid, e_sv);
            if (e_qv) chk("req_data", req_data, byp_q ? tdata[QW-1:0] : mq_req[0]);
            if (e_sv) chk("rsp_data", rsp_data, byp_s ? {16'h0, tdata[SW-1:0]} : {16'h0, mq_rsp[0]});
            chk("req_cnt", req_cnt, m_req_cnt);
            chk("rsp_cnt", rsp_cnt, m_rsp_cnt);
            // What the coming edge does.
            if (mq_req.size() > 0 && req_ready) void'(mq_req.pop_front());
            if (mq_rsp.size() > 0 && rsp_ready) void'(mq_rsp.pop_front());
            if (tvalid && e_tready) begin
                if (hdr) begin
                    m_rsp_cnt = m_rsp_cnt + 32'd1;
                    if (!byp_s) mq_rsp.push_back(tdata[SW-1:0]);
                end else begin
                    m_req_cnt = m_req_cnt + 32'd1;
                    if (!byp_q) mq_req.push_back(tdata[QW-1:0]);
                end
            end
        end
    end

    // Present one beat (called just after a posedge) and hold it until accepted;
    // returns just after the accepting edge.
    task automatic send(input bit hdr, input logic [63:0] pl);
        bit done = 1'b0;
        tvalid = 1'b1;
        tdata  = {7'($urandom), hdr, pl};
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            if (tready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %h never accepted", pl);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit pending;
        rst = 1'b1; tvalid = 1'b0; tdata = '0; req_ready = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        chk("idle_tready", tready, 1);
        chk("idle_req_valid", req_valid, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_req_cnt", req_cnt, 0);

        // Three request beats, consumer always ready.
        req_ready = 1'b1;
        send(0, 64'h11);
        if (!Byp) chk("req_first_lat1", req_data, 64'h11);
        send(0, 64'h22);
        if (!Byp) chk("req_second", req_data, 64'h22);
        send(0, 64'h33);
        if (!Byp) chk("req_third", req_data, 64'h33);
        idle(3);
        chk("req_cnt_3", req_cnt, 32'd3);
        chk("req_drained", req_valid, 0);

        // Five response beats into a depth-4 buffer with the consumer stalled.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(1, 64'h100 + 64'(i));
        tvalid = 1'b1;
        tdata  = {7'h0, 1'b1, 64'h105};
        @(negedge clk); #1;
        chk("rsp_full_tready", tready, 0);
        @(posedge clk); #1;
        chk("rsp_full_hold", tready, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_space_after_pop", tready, 1);
        @(posedge clk); #1;
        idle(8);
        chk("rsp_cnt_5", rsp_cnt, 32'd5);

        // Response path full and stalled must not block a request.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 64'h200 + 64'(i));
        send(0, 64'hAB);
        if (!Byp) begin
            chk("hol_req_valid", req_valid, 1);
            chk("hol_req_data", req_data, 64'hAB);
        end
        idle(1);
        chk("hol_rsp_still_full", rsp_valid, 1);
        rsp_ready = 1'b1;
        idle(6);

        // 48-bit truncation of a response payload.
        rsp_ready = 1'b0;
        send(1, 64'hFFFF_0000_1234_5678);
        idle(1);
        chk("rsp_trunc", rsp_data, 64'h0000_1234_5678);
        rsp_ready = 1'b1;
        idle(2);

        // Reset with two entries in each buffer.
        req_ready = 1'b0;
        rsp_ready = 1'b0;
        send(0, 64'hA1); send(0, 64'hA2); send(1, 64'hB1); send(1, 64'hB2);
        idle(1);
        rst = 1'b1;
        #1;
        chk("arst_req_valid", req_valid, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_cnt", req_cnt, 0);
        chk("arst_rsp_cnt", rsp_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_ready = 1'b1;
        rsp_ready = 1'b1;
        idle(2);
        chk("post_rst_empty", req_valid, 0);
        send(0, 64'h77);
        idle(3);
        chk("post_rst_req_cnt", req_cnt, 32'd1);

`ifdef FLOO_AXIS_BRIDGE_RX_BYPASS_EN
        // Zero-latency pass-through into an empty buffer.
        req_ready = 1'b1;
        tvalid = 1'b1;
        tdata  = {7'h0, 1'b0, 64'h5A};
        #1;
        chk("byp_valid", req_valid, 1);
        chk("byp_data", req_data, 64'h5A);
        @(posedge clk); #1;
        idle(2);
`endif

        // Random traffic; a stalled beat is held unchanged until accepted.
        pending = 1'b0;
        repeat (3000) begin
            @(posedge clk); #1;
            req_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (!pending) begin
                tvalid = ($urandom_range(0, 3) != 0);
                tdata  = {8'($urandom), $urandom, $urandom};
            end
            @(negedge clk); #1;
            pending = tvalid && !tready;
        end
        @(posedge clk); #1;
        req_ready = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && pending; i++) begin
            @(negedge clk); #1;
            pending = tvalid && !tready;
            @(posedge clk); #1;
        end
        idle(DEPTH + 3);
        chk("final_req_empty", req_valid, 0);
        chk("final_rsp_empty", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
